// File: rtl/register_file_pkg.sv
// Shared typedefs for the single-cycle core: data width, register index,
// register-file clear FSM states and the ALU operation set.
package register_file_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] reg_addr_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clear_state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_e;

    function automatic logic [XLEN-1:0] alu_exec(input alu_op_e op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [XLEN-1:0] result;
        result = '0;
        unique case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks registers 1..NREGS-1 one per cycle and
// raises ready on the edge that zeroes the last one.
module regfile_clear_seq
    import register_file_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic      clk,
    input  logic      rst,
    output reg_addr_t clearAddr,
    output logic      clearActive,
    output logic      ready
);

    localparam reg_addr_t LAST_ADDR = reg_addr_t'(NREGS - 1);

    clear_state_e state_q, state_d;
    reg_addr_t    count_q, count_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            count_q <= reg_addr_t'(1);
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            CLEAR: begin
                count_d = count_q + reg_addr_t'(1);
                if (count_q == LAST_ADDR) begin
                    state_d = READY;
                end
            end
            READY: begin
                count_d = count_q;
            end
            default: state_d = CLEAR;
        endcase
    end

    assign clearAddr   = count_q;
    assign clearActive = (state_q == CLEAR);
    assign ready       = (state_q == READY);

endmodule

// File: rtl/register_file.sv
// Two-read/one-write register file with hardwired x0 and a post-reset clear.
// Define REGFILE_BYPASS_EN for write-first reads; default build is read-first.
module register_file #(
    parameter int XLEN  = register_file_pkg::XLEN,
    parameter int NREGS = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  register_file_pkg::reg_addr_t rs1Addr,
    input  register_file_pkg::reg_addr_t rs2Addr,
    input  register_file_pkg::reg_addr_t rdAddr,
    input  logic                        writeEnable,
    input  logic [XLEN-1:0]             writeData,
    output logic [XLEN-1:0]             readData1,
    output logic [XLEN-1:0]             readData2,
    output logic                        ready
);

    import register_file_pkg::*;

    reg_addr_t       clear_addr;
    logic            clear_active;
    logic            commit;
    logic            mem_we;
    reg_addr_t       mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] regs_q [NREGS];

    regfile_clear_seq #(
        .NREGS(NREGS)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .clearAddr  (clear_addr),
        .clearActive(clear_active),
        .ready      (ready)
    );

    // A user write only lands once the clear has finished; earlier ones are dropped.
    assign commit = writeEnable && ready && !rst && (rdAddr != '0);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = rdAddr;
        mem_wdata = writeData;
        if (clear_active) begin
            mem_we    = 1'b1;
            mem_waddr = clear_addr;
            mem_wdata = '0;
        end else if (commit) begin
            mem_we = 1'b1;
        end
    end

    // NOTE: storage has no reset; the clear sequencer zeroes it after reset,
    // which keeps the array mappable onto plain flops or RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            regs_q[mem_waddr] <= mem_wdata;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input reg_addr_t addr);
        logic [XLEN-1:0] value;
        value = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
        if (commit && (addr == rdAddr)) begin
            value = writeData;
        end
`endif
        if (!ready || (addr == '0)) begin
            value = '0;
        end
        return value;
    endfunction

    always_comb begin
        readData1 = read_port(rs1Addr);
        readData2 = read_port(rs2Addr);
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (either REGFILE_BYPASS_EN build).
module tb_register_file;

    import register_file_pkg::*;

    logic        clk;
    logic        rst;
    reg_addr_t   rs1Addr;
    reg_addr_t   rs2Addr;
    reg_addr_t   rdAddr;
    logic        writeEnable;
    logic [31:0] writeData;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic        ready;

    int checks;
    int errors;

    register_file #(
        .XLEN (32),
        .NREGS(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rs1Addr    (rs1Addr),
        .rs2Addr    (rs2Addr),
        .rdAddr     (rdAddr),
        .writeEnable(writeEnable),
        .writeData  (writeData),
        .readData1  (readData1),
        .readData2  (readData2),
        .ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then step off it so inputs and samples are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release reset and verify the 31-edge clear window with reads masked to 0.
    task automatic check_clear_window(input string tag);
        for (int e = 1; e <= 31; e++) begin
            rs1Addr = reg_addr_t'(e);
            rs2Addr = reg_addr_t'(31 - e);
            tick();
            check({tag, "_ready"}, {31'd0, ready}, (e == 31) ? 32'd1 : 32'd0);
            if (e < 31) begin
                check({tag, "_rd1"}, readData1, 32'd0);
                check({tag, "_rd2"}, readData2, 32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] bypass_exp;
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        rs1Addr     = '0;
        rs2Addr     = '0;
        rdAddr      = '0;
        writeEnable = 1'b0;
        writeData   = '0;

        tick();
        tick();
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_rd1", readData1, 32'd0);
        rst = 1'b0;
        check_clear_window("clr1");

        writeEnable = 1'b1;
        rdAddr      = 5'd5;
        writeData   = 32'd10;
        tick();
        rdAddr    = 5'd6;
        writeData = 32'd15;
        tick();
        writeEnable = 1'b0;
        rs1Addr     = 5'd5;
        rs2Addr     = 5'd6;
        #1;
        check("x5", readData1, 32'd10);
        check("x6", readData2, 32'd15);
        check("alu_add", alu_exec(ALU_ADD, readData1, readData2), 32'd25);
        check("alu_sub", alu_exec(ALU_SUB, readData1, readData2), 32'hFFFF_FFFB);

        rs1Addr = 5'd6;
        #1;
        check("same_rd1", readData1, 32'd15);
        check("same_rd2", readData2, 32'd15);

        writeEnable = 1'b1;
        rdAddr      = 5'd0;
        writeData   = 32'hDEAD_BEEF;
        rs1Addr     = 5'd0;
        #1;
        check("x0_during", readData1, 32'd0);
        tick();
        writeEnable = 1'b0;
        #1;
        check("x0_after", readData1, 32'd0);

`ifdef REGFILE_BYPASS_EN
        bypass_exp = 32'h1234;
`else
        bypass_exp = 32'h0;
`endif
        writeEnable = 1'b1;
        rdAddr      = 5'd7;
        writeData   = 32'h1234;
        rs1Addr     = 5'd7;
        rs2Addr     = 5'd5;
        #1;
        check("x7_same_cycle", readData1, bypass_exp);
        check("x5_unaffected", readData2, 32'd10);
        tick();
        writeEnable = 1'b0;
        #1;
        check("x7_next_cycle", readData1, 32'h1234);

        writeEnable = 1'b1;
        rdAddr      = 5'd9;
        writeData   = 32'd7;
        tick();
        writeEnable = 1'b0;
        rs1Addr     = 5'd9;
        #1;
        check("x9_written", readData1, 32'd7);

        // Reset again, attempt a write into x3 throughout, and restart mid-clear.
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        writeEnable = 1'b1;
        rdAddr      = 5'd3;
        writeData   = 32'd99;
        for (int e = 1; e <= 9; e++) begin
            tick();
            check("clr2_ready", {31'd0, ready}, 32'd0);
        end
        rst = 1'b1;
        tick();
        check("midclr_ready", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        check_clear_window("clr3");

        writeEnable = 1'b0;
        rs1Addr     = 5'd9;
        rs2Addr     = 5'd3;
        #1;
        check("x9_cleared", readData1, 32'd0);
        check("x3_not_queued", readData2, 32'd0);

        writeEnable = 1'b1;
        rdAddr      = 5'd3;
        writeData   = 32'd99;
        tick();
        writeEnable = 1'b0;
        #1;
        check("x3_after_ready", readData2, 32'd99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
